load_sequencer: RTL and testbench
=================================

# load_sequencer

Front-end controller that owns the tiny processor's caches whenever the processor is not executing. It deserialises 12-bit write frames from the SPI master, range-checks them, and issues single-cycle write strobes to the instruction or data cache. It also arbitrates between master loading and program execution, and releases the processor (`proc_run`) only when no frame is in flight.

## Interface
Parameters:
- `DATA_W`, 8, cache word width
- `ADDR_W`, 4, cache address width
- `IMEM_SZ`, 16, icache entries; addresses 0..IMEM_SZ-1 legal
- `DMEM_SZ`, 15, dcache entries; addresses 0..DMEM_SZ-1 legal

Ports:
- `clk` in 1: single clock; master shifts on this clock
- `rst_n` in 1: asynchronous, active-low reset
- `csi_n` in 1: icache chip select, active low
- `csd_n` in 1: dcache chip select, active low
- `mosi` in 1: serial data, sampled on `clk` rising edge while a select is low
- `run_in` in 1: master request to execute
- `icache_wen` out 1: one-cycle icache write strobe
- `dcache_wen` out 1: one-cycle dcache write strobe
- `wr_addr` out ADDR_W: write address, registered
- `wr_data` out DATA_W: write data, registered
- `proc_run` out 1: high means processor executes; low holds PC in reset
- `busy` out 1: frame being received or committed
- `err` out 1: sticky frame-error flag; cleared by reset or on entry to RUN

## Operation
- Reset: state IDLE; all outputs 0.
- States:
  - IDLE: if `run_in`, go to RUN. Else if exactly one select is low, go to SHIFT with the select latched, and capture the first `mosi` bit in the same edge.
  - SHIFT: shift `mosi` MSB-first into a 12-bit buffer; the bit counter saturates at 13. When the latched select rises, go to CHECK.
  - CHECK: one cycle. The frame is valid when count==12 and the address is in range. Valid frame: go to COMMIT. Invalid frame: set `err` and go to IDLE.
  - COMMIT: one cycle. Assert the wen of the latched cache; `wr_addr`/`wr_data` are valid. Go to IDLE.
  - RUN: `proc_run`=1 and selects are ignored. When `run_in` falls, go to IDLE.
- Frame layout: buffer[11:4] is data, buffer[3:0] is address. The first bit received ends up in data[7].
- Range rules: icache address must be < IMEM_SZ; dcache address must be < DMEM_SZ, so 15 is an error.
- Both selects low in IDLE: illegal. Stay IDLE and set `err`.
- The other select falling during SHIFT is ignored.
- `run_in` outside IDLE is deferred. RUN is entered from IDLE once the frame is done, provided `run_in` is still high.
- `wr_addr`/`wr_data` are loaded only when entering COMMIT. They hold their value until the next commit.
- `busy` is 1 in SHIFT, CHECK and COMMIT.
- Asynchronous reset at any point aborts the frame with no wen pulse.

## Timing
- The wen pulse rises 2 cycles after the first cycle the select is sampled high (SHIFT→CHECK→COMMIT).
- The wen pulse is exactly 1 cycle wide, at most one per frame.
- `proc_run` rises 1 cycle after `run_in` is sampled high in IDLE, and falls 1 cycle after `run_in` is sampled low.
- Minimum gap between frames is 2 idle select cycles; a select falling during CHECK/COMMIT is not seen until IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `LOAD_PARITY_EN` defined:
  - A frame is 13 bits: 12 payload bits plus a trailing even-parity bit over all 13.
  - Valid requires count==13 and correct parity; the counter saturates at 14.
  - A parity mismatch sets `err` and discards the frame.
- `LOAD_PARITY_EN` undefined: 12-bit frames, no parity check.

## Structure
- Shared package `tiny_proc_pkg` holds:
  - the state enum (IDLE, SHIFT, CHECK, COMMIT, RUN)
  - `FRAME_BITS` (12, or 13 with parity)
  - `DATA_W`, `ADDR_W`, `IMEM_SZ`, `DMEM_SZ` defaults
- Sub-module `frame_shifter` contains the shift buffer, the saturating bit counter and the parity accumulator. It has `clear`/`shift` inputs and `buf`/`count`/`parity_ok` outputs.
- The FSM, range check and output registers stay in `load_sequencer`.

## Test plan
- Reset check: after `rst_n` low, all outputs are 0.
  - Drive `csi_n` low for 12 bits 0xA5 then 0x3, then high → `icache_wen` pulses once 2 cycles later with `wr_addr`=3, `wr_data`=0xA5.
- `csd_n` frame with data 0x7F, address 0xF → no `dcache_wen`, `err`=1. Then address 0xE → `dcache_wen` pulses with `wr_addr`=0xE, `wr_data`=0x7F.
- Short frame (11 bits) and long frame (14 bits) on `csi_n` → no wen, `err`=1, `wr_addr`/`wr_data` unchanged.
- Raise `run_in` mid-frame → frame commits normally, then `proc_run`=1 one cycle after IDLE. Select toggles during RUN → no wen. `run_in` low → `proc_run`=0 next cycle.
- `csi_n` and `csd_n` fall in the same cycle → no SHIFT, `err`=1. Pulse `rst_n` low mid-SHIFT → no wen, all outputs 0.
- With `LOAD_PARITY_EN`: 13-bit frame 0x015 with correct parity → wen. Flip the parity bit → `err`=1, no wen.

Source files
------------

// File: rtl/load_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// tiny_proc_pkg
// Shared constants for the tiny processor's cache loader:
//   - default cache geometry (DATA_W, ADDR_W, IMEM_SZ, DMEM_SZ)
//   - serial frame length FRAME_BITS and bit-counter sizing
//   - load_sequencer state encoding (IDLE, SHIFT, CHECK, COMMIT, RUN)
//   - address range helper
// Build option: LOAD_PARITY_EN adds a trailing even-parity bit to each frame.
// -----------------------------------------------------------------------------
package tiny_proc_pkg;

  localparam int DATA_W_DEFAULT  = 8;
  localparam int ADDR_W_DEFAULT  = 4;
  localparam int IMEM_SZ_DEFAULT = 16;
  localparam int DMEM_SZ_DEFAULT = 15;

  // Payload is always {data, addr}; parity, when present, trails it.
  localparam int PAYLOAD_W = DATA_W_DEFAULT + ADDR_W_DEFAULT;
`ifdef LOAD_PARITY_EN
  localparam int FRAME_BITS = PAYLOAD_W + 1;
`else
  localparam int FRAME_BITS = PAYLOAD_W;
`endif

  // Counter saturates one past a full frame so over-long frames stay invalid.
  localparam int CNT_MAX = FRAME_BITS + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // State encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SHIFT  = 3'd1;
  localparam state_t ST_CHECK  = 3'd2;
  localparam state_t ST_COMMIT = 3'd3;
  localparam state_t ST_RUN    = 3'd4;

  function automatic logic addr_in_range(input int addr, input int size);
    return addr < size;
  endfunction

endpackage

// File: rtl/load_sequencer_frame_shifter.sv
// -----------------------------------------------------------------------------
// frame_shifter
// Serial-to-parallel buffer for load frames. MSB-first shift register, a
// saturating bit counter and (with LOAD_PARITY_EN) a running parity.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear_i       : restart the frame (may coincide with shift_i)
//   shift_i       : shift bit_i in this cycle
//   bit_i         : serial data bit
//   frame_buf_o   : received payload {data, addr}
//   count_o       : bits received, saturating at FRAME_BITS+1
//   parity_ok_o   : even parity over all bits so far (constant 1 without
//                   LOAD_PARITY_EN)
// -----------------------------------------------------------------------------
module frame_shifter
  import tiny_proc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 shift_i,
  input  logic                 bit_i,
  output logic [PAYLOAD_W-1:0] frame_buf_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 parity_ok_o
);

  logic [FRAME_BITS-1:0] buf_q, buf_d, buf_base;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_base;

  // clear and shift together start a new frame with bit_i as its first bit.
  always_comb begin
    buf_base = clear_i ? '0 : buf_q;
    cnt_base = clear_i ? '0 : cnt_q;
    buf_d    = buf_base;
    cnt_d    = cnt_base;
    if (shift_i) begin
      buf_d = {buf_base[FRAME_BITS-2:0], bit_i};
      if (cnt_base != CNT_W'(CNT_MAX)) begin
        cnt_d = cnt_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef LOAD_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = clear_i ? 1'b0 : par_q;
    if (shift_i) begin
      par_d = par_d ^ bit_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign parity_ok_o = ~par_q;
`else
  assign parity_ok_o = 1'b1;
`endif

  // The parity bit (if any) sits in bit 0; the payload is above it.
  assign frame_buf_o = buf_q[FRAME_BITS-1 -: PAYLOAD_W];
  assign count_o     = cnt_q;

endmodule

// File: rtl/load_sequencer.sv
// -----------------------------------------------------------------------------
// load_sequencer
// Owns the instruction/data caches while the processor is halted. Receives
// serial write frames {data[7:0], addr[3:0]} (MSB first) selected by csi_n or
// csd_n, range-checks them and issues a one-cycle write strobe. Arbitrates
// between loading and execution: proc_run is raised only from IDLE.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   csi_n, csd_n          : icache / dcache frame select, active low
//   mosi                  : serial data, sampled while a select is low
//   run_in                : request to execute (deferred while a frame is busy)
//   icache_wen/dcache_wen : one-cycle write strobes
//   wr_addr, wr_data      : registered write address/data, held between commits
//   proc_run              : processor executes when high
//   busy                  : frame being received, checked or committed
//   err                   : sticky frame error, cleared on entry to RUN
// Build option: LOAD_PARITY_EN selects 13-bit frames with even parity.
// -----------------------------------------------------------------------------
module load_sequencer
  import tiny_proc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int IMEM_SZ = IMEM_SZ_DEFAULT,
  parameter int DMEM_SZ = DMEM_SZ_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csi_n,
  input  logic              csd_n,
  input  logic              mosi,
  input  logic              run_in,
  output logic              icache_wen,
  output logic              dcache_wen,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              proc_run,
  output logic              busy,
  output logic              err
);

  state_t              state_q, state_d;
  logic                sel_i_q, sel_i_d;     // 1: frame targets icache
  logic                err_q, err_d;
  logic                iwen_q, iwen_d;
  logic                dwen_q, dwen_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                run_q, run_d;
  logic                busy_q, busy_d;

  logic                sh_clear, sh_shift;
  logic [PAYLOAD_W-1:0] frame_buf;
  logic [CNT_W-1:0]    frame_cnt;
  logic                parity_ok;
  logic [ADDR_W-1:0]   frame_addr;
  logic [DATA_W-1:0]   frame_data;
  logic                addr_ok;
  logic                frame_ok;
  logic                sel_released;

  frame_shifter u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (sh_clear),
    .shift_i     (sh_shift),
    .bit_i       (mosi),
    .frame_buf_o (frame_buf),
    .count_o     (frame_cnt),
    .parity_ok_o (parity_ok)
  );

  assign frame_addr   = frame_buf[ADDR_W-1:0];
  assign frame_data   = frame_buf[PAYLOAD_W-1 -: DATA_W];
  assign addr_ok      = sel_i_q ? addr_in_range(int'(frame_addr), IMEM_SZ)
                                : addr_in_range(int'(frame_addr), DMEM_SZ);
  assign frame_ok     = (frame_cnt == CNT_W'(FRAME_BITS)) && addr_ok && parity_ok;
  // Only the select latched at frame start can end the frame.
  assign sel_released = sel_i_q ? csi_n : csd_n;

  always_comb begin
    state_d   = state_q;
    sel_i_d   = sel_i_q;
    err_d     = err_q;
    iwen_d    = 1'b0;
    dwen_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    sh_clear  = 1'b0;
    sh_shift  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run_in) begin
          state_d = ST_RUN;
        end else if (csi_n ^ csd_n) begin
          state_d  = ST_SHIFT;
          sel_i_d  = ~csi_n;
          sh_clear = 1'b1;
          sh_shift = 1'b1;
        end else if (!csi_n && !csd_n) begin
          err_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (sel_released) begin
          state_d = ST_CHECK;
        end else begin
          sh_shift = 1'b1;
        end
      end
      ST_CHECK: begin
        // Strobe and write bus are registered here so they appear in COMMIT.
        if (frame_ok) begin
          state_d   = ST_COMMIT;
          iwen_d    = sel_i_q;
          dwen_d    = ~sel_i_q;
          wr_addr_d = frame_addr;
          wr_data_d = frame_data;
        end else begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (!run_in) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
      err_d = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they line up with it.
  assign run_d  = (state_d == ST_RUN);
  assign busy_d = (state_d == ST_SHIFT) || (state_d == ST_CHECK) ||
                  (state_d == ST_COMMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_i_q   <= 1'b0;
      err_q     <= 1'b0;
      iwen_q    <= 1'b0;
      dwen_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_i_q   <= sel_i_d;
      err_q     <= err_d;
      iwen_q    <= iwen_d;
      dwen_q    <= dwen_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      run_q     <= run_d;
      busy_q    <= busy_d;
    end
  end

  assign icache_wen = iwen_q;
  assign dcache_wen = dwen_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign proc_run   = run_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_load_sequencer
// Transaction-driven bench: each stimulus task knows from the frame rules what
// every output must be on every future cycle and writes that into per-cycle
// expectation arrays; a compare process checks the DUT against them each
// cycle. Directed literal checks pin the expectations for the listed cases.
// -----------------------------------------------------------------------------
module tb_load_sequencer;

  localparam int IMEM_SZ = 16;
  localparam int DMEM_SZ = 15;
`ifdef LOAD_PARITY_EN
  localparam int FB = 13;
`else
  localparam int FB = 12;
`endif
  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       csi_n = 1'b1;
  logic       csd_n = 1'b1;
  logic       mosi = 1'b0;
  logic       run_in = 1'b0;
  logic       icache_wen, dcache_wen, proc_run, busy, err;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  load_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .csi_n      (csi_n),
    .csd_n      (csd_n),
    .mosi       (mosi),
    .run_in     (run_in),
    .icache_wen (icache_wen),
    .dcache_wen (dcache_wen),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .proc_run   (proc_run),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc    = 0;   // posedges seen so far; outputs "at cyc" follow that edge
  int passed = 0;
  int total  = 0;
  int iw_cnt = 0;
  int dw_cnt = 0;

  // Expected outputs per cycle
  bit       e_busy [MAXC];
  bit       e_iw   [MAXC];
  bit       e_dw   [MAXC];
  bit       e_err  [MAXC];
  bit       e_run  [MAXC];
  bit [3:0] e_addr [MAXC];
  bit [7:0] e_data [MAXC];

  function automatic void set_err(input int from, input bit v);
    for (int i = from; i < MAXC; i++) e_err[i] = v;
  endfunction

  function automatic void set_run(input int from, input bit v);
    for (int i = from; i < MAXC; i++) e_run[i] = v;
  endfunction

  function automatic void set_wr(input int from, input bit [3:0] a, input bit [7:0] d);
    for (int i = from; i < MAXC; i++) begin
      e_addr[i] = a;
      e_data[i] = d;
    end
  endfunction

  function automatic void set_busy(input int a, input int b);
    for (int i = a; i <= b && i < MAXC; i++) e_busy[i] = 1'b1;
  endfunction

  function automatic void zero_from(input int from);
    for (int i = from; i < MAXC; i++) begin
      e_busy[i] = 1'b0;
      e_iw[i]   = 1'b0;
      e_dw[i]   = 1'b0;
    end
    set_err(from, 1'b0);
    set_run(from, 1'b0);
    set_wr(from, 4'h0, 8'h00);
  endfunction

  function automatic logic [19:0] make_bits(input logic [11:0] pl);
`ifdef LOAD_PARITY_EN
    return {7'd0, pl, ^pl};
`else
    return {8'd0, pl};
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Cycle counter and per-cycle compare
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(negedge clk);
    if (icache_wen === 1'b1) iw_cnt++;
    if (dcache_wen === 1'b1) dw_cnt++;
    if (rst_n === 1'b1 && cyc < MAXC) begin
      total++;
      if ({busy, icache_wen, dcache_wen, err, proc_run, wr_addr, wr_data} ===
          {e_busy[cyc], e_iw[cyc], e_dw[cyc], e_err[cyc], e_run[cyc], e_addr[cyc], e_data[cyc]})
        passed++;
      else
        $display("FAIL cycle %0d: got busy=%b iwen=%b dwen=%b err=%b run=%b addr=%h data=%h, expected busy=%b iwen=%b dwen=%b err=%b run=%b addr=%h data=%h",
                 cyc, busy, icache_wen, dcache_wen, err, proc_run, wr_addr, wr_data,
                 e_busy[cyc], e_iw[cyc], e_dw[cyc], e_err[cyc], e_run[cyc], e_addr[cyc], e_data[cyc]);
    end
  end

  // One frame of n bits (bits[n-1] first). Starts with the FSM idle and
  // returns just before the first edge at which it is idle again.
  task automatic send_frame(input bit is_i, input int n, input logic [19:0] bits,
                            input bit raise_run);
    int          s, nidle;
    logic [11:0] pl;
    bit          ok;
    s  = cyc + 1;
    pl = bits[FB-1 -: 12];
    ok = (n == FB) && (is_i ? (int'(pl[3:0]) < IMEM_SZ) : (int'(pl[3:0]) < DMEM_SZ));
`ifdef LOAD_PARITY_EN
    if (^bits[FB-1:0]) ok = 1'b0;
`endif
    set_busy(s, s + n + (ok ? 1 : 0));
    if (ok) begin
      if (s + n + 1 < MAXC) begin
        if (is_i) e_iw[s+n+1] = 1'b1;
        else      e_dw[s+n+1] = 1'b1;
      end
      set_wr(s + n + 1, pl[3:0], pl[11:4]);
    end else begin
      set_err(s + n + 1, 1'b1);
    end
    nidle = s + n + (ok ? 3 : 2);
    if (raise_run) begin
      set_run(nidle, 1'b1);
      set_err(nidle, 1'b0);
    end
    for (int j = 0; j < n; j++) begin
      if (raise_run && j == n / 2) run_in = 1'b1;
      mosi = bits[n-1-j];
      if (is_i) begin
        csi_n = 1'b0;
        csd_n = (j == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end else begin
        csd_n = 1'b0;
        csi_n = (j == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      step();
    end
    csi_n = 1'b1;
    csd_n = 1'b1;
    mosi  = 1'($urandom_range(0, 1));
    while (cyc < nidle - 1) step();
  endtask

  // run_in held high with selects toggling, then dropped.
  task automatic run_hold(input int len);
    for (int i = 0; i < len; i++) begin
      run_in = 1'b1;
      csi_n  = 1'($urandom_range(0, 1));
      csd_n  = 1'($urandom_range(0, 1));
      mosi   = 1'($urandom_range(0, 1));
      step();
    end
    chk("proc_run_high", int'(proc_run), 1);
    run_in = 1'b0;
    csi_n  = 1'b1;
    csd_n  = 1'b1;
    set_run(cyc + 1, 1'b0);
    step();
    chk("proc_run_fell", int'(proc_run), 0);
  endtask

  task automatic run_phase(input int len);
    set_run(cyc + 1, 1'b1);
    set_err(cyc + 1, 1'b0);
    run_in = 1'b1;
    csi_n  = 1'b1;
    csd_n  = 1'b1;
    step();
    run_hold(len);
  endtask

  task automatic both_low();
    set_err(cyc + 1, 1'b1);
    run_in = 1'b0;
    csi_n  = 1'b0;
    csd_n  = 1'b0;
    step();
    csi_n = 1'b1;
    csd_n = 1'b1;
  endtask

  task automatic reset_mid_shift(input bit is_i, input int k);
    set_busy(cyc + 1, cyc + k);
    for (int j = 0; j < k; j++) begin
      mosi = 1'($urandom_range(0, 1));
      if (is_i) csi_n = 1'b0;
      else      csd_n = 1'b0;
      step();
    end
    #1;
    rst_n = 1'b0;
    csi_n = 1'b1;
    csd_n = 1'b1;
    zero_from(cyc + 1);
    #1;
    chk("rst_mid_outputs",
        int'({busy, icache_wen, dcache_wen, err, proc_run, wr_addr, wr_data}), 0);
    step();
    step();
    #1;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the end, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          r, n, k, iw0, dw0;
    bit          is_i, rr;
    logic [11:0] pl;
    logic [19:0] bits;

    // Reset
    rst_n = 1'b0;
    repeat (3) step();
    chk("reset_busy", int'(busy), 0);
    chk("reset_wen", int'({icache_wen, dcache_wen}), 0);
    chk("reset_err_run", int'({err, proc_run}), 0);
    chk("reset_wr", int'({wr_addr, wr_data}), 0);
    #1;
    rst_n = 1'b1;
    step();

    // icache frame data A5 addr 3
    send_frame(1'b1, FB, make_bits(12'hA53), 1'b0);
    chk("a53_wen_once", iw_cnt, 1);
    chk("a53_addr", int'(wr_addr), 'h3);
    chk("a53_data", int'(wr_data), 'hA5);
    chk("a53_err", int'(err), 0);

    // dcache address 15 is out of range, 14 is fine
    send_frame(1'b0, FB, make_bits(12'h7FF), 1'b0);
    chk("d7ff_err", int'(err), 1);
    chk("d7ff_nowen", dw_cnt, 0);
    chk("d7ff_addr_held", int'(wr_addr), 'h3);
    send_frame(1'b0, FB, make_bits(12'h7FE), 1'b0);
    chk("d7fe_wen_once", dw_cnt, 1);
    chk("d7fe_addr", int'(wr_addr), 'hE);
    chk("d7fe_data", int'(wr_data), 'h7F);

    // Short and long frames
    run_phase(2);
    chk("run_clears_err", int'(err), 0);
    send_frame(1'b1, FB - 1, 20'h00A53, 1'b0);
    chk("short_err", int'(err), 1);
    chk("short_nowen", iw_cnt, 1);
    chk("short_wr_held", int'({wr_addr, wr_data}), 'hE7F);
    run_phase(1);
    send_frame(1'b1, FB + 2, 20'h0A530, 1'b0);
    chk("long_err", int'(err), 1);
    chk("long_nowen", iw_cnt, 1);
    chk("long_wr_held", int'({wr_addr, wr_data}), 'hE7F);

    // run_in raised mid-frame: commit first, then run
    send_frame(1'b1, FB, make_bits(12'h3C1), 1'b1);
    chk("midrun_wen", iw_cnt, 2);
    chk("midrun_addr", int'(wr_addr), 'h1);
    chk("midrun_data", int'(wr_data), 'h3C);
    iw0 = iw_cnt;
    dw0 = dw_cnt;
    run_hold(6);
    chk("run_sel_ignored", iw_cnt + dw_cnt, iw0 + dw0);

    // Both selects together
    both_low();
    chk("both_low_err", int'(err), 1);
    chk("both_low_busy", int'(busy), 0);

    // Reset in the middle of a frame
    iw0 = iw_cnt;
    reset_mid_shift(1'b1, 5);
    repeat (FB) step();
    chk("rst_mid_nowen", iw_cnt, iw0);

`ifdef LOAD_PARITY_EN
    // payload 0x015 has three ones, so the parity bit is 1
    send_frame(1'b1, 13, 20'h0002B, 1'b0);
    chk("par_ok_wen", iw_cnt, iw0 + 1);
    chk("par_ok_addr", int'(wr_addr), 'h5);
    chk("par_ok_data", int'(wr_data), 'h01);
    send_frame(1'b1, 13, 20'h0002A, 1'b0);
    chk("par_bad_err", int'(err), 1);
    chk("par_bad_nowen", iw_cnt, iw0 + 1);
`endif

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        is_i = 1'($urandom_range(0, 1));
        k    = $urandom_range(0, 9);
        if (k < 7)       n = FB;
        else if (k == 7) n = FB - 1 - $urandom_range(0, 3);
        else             n = FB + 1 + $urandom_range(0, 3);
        pl = 12'($urandom);
        if ($urandom_range(0, 3) == 0) pl[3:0] = 4'hF;
        bits = (n == FB) ? make_bits(pl) : 20'($urandom);
`ifdef LOAD_PARITY_EN
        if ($urandom_range(0, 3) == 0) bits[0] = ~bits[0];
`endif
        rr = ($urandom_range(0, 9) == 0);
        send_frame(is_i, n, bits, rr);
        if (rr) run_hold($urandom_range(1, 4));
      end else if (r < 75) begin
        both_low();
      end else if (r < 90) begin
        run_phase($urandom_range(1, 4));
      end else begin
        repeat ($urandom_range(1, 3)) step();
      end
    end

    repeat (4) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
